// File: rtl/uart_frame_loader.sv
// Frame loader from a UART byte stream into a frame-buffer write port: arm, hunt for sync, pack pixels.
// Define FRAME_CHECKSUM_EN to require a trailing modulo-256 checksum byte before a frame counts as good.
module uart_frame_loader #(
  parameter int unsigned IMG_WIDTH       = 128,
  parameter int unsigned IMG_HEIGHT      = 128,
  parameter int unsigned BYTES_PER_PIXEL = 1,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  localparam int unsigned N_PIX  = IMG_WIDTH * IMG_HEIGHT,
  localparam int unsigned PW     = 8 * BYTES_PER_PIXEL,
  localparam int unsigned ADDR_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic              clk,
  input  logic              rst_n_in,
  input  logic [7:0]        rx_data_in,
  input  logic              rx_valid_in,
  input  logic              arm_in,
  input  logic              abort_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [PW-1:0]     wr_data_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              frame_error_out,
  output logic [7:0]        frame_count_out,
  output logic [1:0]        state_out
);

  localparam int unsigned LANE_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [PW-1:0]       pack_q, pack_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PW-1:0]       wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [7:0]          count_q, count_d;
  logic [PW-1:0]       pack_shift_c;
  logic                timeout_c;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  // Next-state and output logic; abort outranks incoming bytes and the timeout.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pix_d     = pix_q;
    idle_d    = idle_q;
    pack_d    = pack_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = error_q;
    count_d   = count_q;
`ifdef FRAME_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    pack_shift_c = (pack_q << 8) | PW'(rx_data_in);
    timeout_c    = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      ST_IDLE: begin
        if (arm_in) begin
          state_d = ST_SYNC;
          error_d = 1'b0;
          pix_d   = '0;
          lane_d  = '0;
          idle_d  = '0;
          pack_d  = '0;
`ifdef FRAME_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end

      ST_SYNC: begin
        if (abort_in) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (rx_valid_in && (rx_data_in == SYNC_BYTE)) begin
          state_d = ST_LOAD;
          idle_d  = '0;
        end
      end

      ST_LOAD: begin
        if (abort_in) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (rx_valid_in) begin
          idle_d = '0;
          pack_d = pack_shift_c;
`ifdef FRAME_CHECKSUM_EN
          sum_d  = sum_q + rx_data_in;
`endif
          if (lane_q == LANE_W'(BYTES_PER_PIXEL - 1)) begin
            lane_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = pix_q;
            wr_data_d = pack_shift_c;
            pix_d     = pix_q + 1'b1;
            if (pix_q == ADDR_W'(N_PIX - 1)) begin
`ifdef FRAME_CHECKSUM_EN
              state_d = ST_CHECK;
              idle_d  = '0;
`else
              state_d = ST_IDLE;
              done_d  = 1'b1;
              count_d = count_q + 8'd1;
`endif
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end else if (timeout_c) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          lane_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

`ifdef FRAME_CHECKSUM_EN
      ST_CHECK: begin
        if (abort_in) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (rx_valid_in) begin
          state_d = ST_IDLE;
          if (rx_data_in == sum_q) begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            error_d = 1'b1;
          end
        end else if (timeout_c) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      pix_q     <= '0;
      idle_q    <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      pix_q     <= pix_d;
      idle_q    <= idle_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      count_q   <= count_d;
`ifdef FRAME_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign wr_en_out       = wr_en_q;
  assign wr_addr_out     = wr_addr_q;
  assign wr_data_out     = wr_data_q;
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;
  assign frame_error_out = error_q;
  assign frame_count_out = count_q;
  assign state_out       = state_q;

endmodule
